// File: rtl/reg_file_scoreboard.sv
// Register file with N combinational read ports, write-to-read bypass and a
// per-register pending-write counter used by decode for hazard detection.
module reg_file_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NREAD    = 2,
  parameter int MAX_PEND = 3,
  localparam int AW      = $clog2(NREG),
  localparam int CW      = $clog2(MAX_PEND + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic                  iss_ready,
  output logic [NREG-1:0]       busy_vec,
  output logic                  err_underflow
);

  localparam logic [CW-1:0] PEND_LIMIT = CW'(MAX_PEND);

  logic [XLEN-1:0] regFile [1:NREG-1];
  logic [CW-1:0]   pendReg [NREG];
  logic            errReg;
  logic            issAccept;
  logic [NREG-1:0] incVec;
  logic [NREG-1:0] decVec;

  // A saturated register can still take an issue when a writeback to it
  // retires one pending write in the same cycle.
  assign iss_ready = (iss_addr == '0)
                  || (pendReg[iss_addr] != PEND_LIMIT)
                  || (wr_en && (wr_addr == iss_addr) && (pendReg[iss_addr] != '0));
  assign issAccept = iss_en && iss_ready;
  assign err_underflow = errReg;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : gReg
      assign incVec[gi]   = (gi != 0) && issAccept && (iss_addr == AW'(gi));
      assign decVec[gi]   = (gi != 0) && wr_en && (wr_addr == AW'(gi)) && (pendReg[gi] != '0);
      assign busy_vec[gi] = (pendReg[gi] != '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++) regFile[r] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regFile[wr_addr] <= wr_data;
    end
  end

  // Entry 0 never sees inc/dec, so it holds zero from reset onwards.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (rst) begin
        pendReg[r] <= '0;
      end else if (incVec[r] && !decVec[r]) begin
        pendReg[r] <= pendReg[r] + CW'(1);
      end else if (decVec[r] && !incVec[r]) begin
        pendReg[r] <= pendReg[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errReg <= 1'b0;
    end else if (wr_en && (wr_addr != '0) && (pendReg[wr_addr] == '0)) begin
      errReg <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NREAD; gi++) begin : gRead
      logic [AW-1:0]   portAddr;
      logic            wrHit;
      logic [XLEN-1:0] portData;

      assign portAddr = rd_addr[gi*AW +: AW];
      assign wrHit    = wr_en && (wr_addr == portAddr);

      always_comb begin
        portData = '0;
        if (portAddr != '0) begin
          portData = wrHit ? wr_data : regFile[portAddr];
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = portData;
      // The retiring writeback is subtracted so the final write reads as ready.
      assign rd_busy[gi] = (portAddr != '0) && (pendReg[portAddr] > CW'(wrHit));
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed table-driven bench for reg_file_scoreboard: each row is one cycle of
// inputs plus the outputs expected before that cycle's clock edge.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic [31:0] busy_vec;
  logic        err_underflow;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .iss_ready(iss_ready), .busy_vec(busy_vec),
    .err_underflow(err_underflow)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        irdy;
    logic [31:0] bvec;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic ie, input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] busy,
                     input logic irdy, input logic [31:0] bvec, input logic err);
    vec_t v;
    v.rst = r; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
    v.ra0 = ra0; v.ra1 = ra1; v.d0 = d0; v.d1 = d1; v.busy = busy;
    v.irdy = irdy; v.bvec = bvec; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; rd_addr = {ra1, ra0};
  endtask

  initial begin
    //   rst we wa  wd            ie ia  ra0 ra1  d0            d1      busy   irdy bvec          err
    // basic write/read (issue first so the writebacks are legitimate)
    add(0, 0, 0,  0,            0, 0,  1,  2,   0,            0,      2'b00, 1, 32'h0,        0);
    add(0, 0, 0,  0,            1, 1,  1,  2,   0,            0,      2'b00, 1, 32'h0,        0);
    add(0, 0, 0,  0,            1, 2,  1,  2,   0,            0,      2'b01, 1, 32'h2,        0);
    add(0, 1, 1,  50,           0, 0,  2,  1,   0,            50,     2'b01, 1, 32'h6,        0);
    add(0, 1, 2,  20,           0, 0,  2,  1,   20,           50,     2'b00, 1, 32'h4,        0);
    add(0, 0, 0,  0,            0, 0,  1,  2,   50,           20,     2'b00, 1, 32'h0,        0);
    // register 0: write and issue are both no-ops
    add(0, 1, 0,  5,            1, 0,  0,  0,   0,            0,      2'b00, 1, 32'h0,        0);
    add(0, 0, 0,  0,            0, 0,  0,  0,   0,            0,      2'b00, 1, 32'h0,        0);
    // bypass
    add(0, 0, 0,  0,            1, 3,  3,  0,   0,            0,      2'b00, 1, 32'h0,        0);
    add(0, 1, 3,  32'h80000005, 0, 0,  3,  0,   32'h80000005, 0,      2'b00, 1, 32'h8,        0);
    add(0, 0, 0,  0,            0, 0,  3,  0,   32'h80000005, 0,      2'b00, 1, 32'h0,        0);
    // saturation of x5 at three pending writes
    add(0, 0, 0,  0,            1, 5,  5,  0,   0,            0,      2'b00, 1, 32'h0,        0);
    add(0, 0, 0,  0,            1, 5,  5,  0,   0,            0,      2'b01, 1, 32'h20,       0);
    add(0, 0, 0,  0,            1, 5,  5,  0,   0,            0,      2'b01, 1, 32'h20,       0);
    add(0, 0, 0,  0,            1, 5,  5,  0,   0,            0,      2'b01, 0, 32'h20,       0);
    add(0, 1, 5,  8,            0, 5,  5,  0,   8,            0,      2'b01, 1, 32'h20,       0);
    add(0, 1, 5,  10,           0, 5,  5,  0,   10,           0,      2'b01, 1, 32'h20,       0);
    add(0, 1, 5,  65547,        0, 5,  5,  0,   65547,        0,      2'b00, 1, 32'h20,       0);
    add(0, 0, 0,  0,            0, 5,  5,  0,   65547,        0,      2'b00, 1, 32'h0,        0);
    // simultaneous issue and writeback on x7
    add(0, 0, 0,  0,            1, 7,  7,  0,   0,            0,      2'b00, 1, 32'h0,        0);
    add(0, 1, 7,  28,           1, 7,  7,  0,   28,           0,      2'b00, 1, 32'h80,       0);
    add(0, 0, 0,  0,            0, 7,  7,  0,   28,           0,      2'b01, 1, 32'h80,       0);
    add(0, 1, 7,  28,           0, 7,  7,  0,   28,           0,      2'b00, 1, 32'h80,       0);
    // underflow on x9, then reset while x5 is pending
    add(0, 1, 9,  32,           0, 0,  9,  0,   32,           0,      2'b00, 1, 32'h0,        0);
    add(0, 0, 0,  0,            0, 0,  9,  0,   32,           0,      2'b00, 1, 32'h0,        1);
    add(0, 0, 0,  0,            1, 5,  5,  9,   65547,        32,     2'b00, 1, 32'h0,        1);
    add(1, 1, 1,  99,           1, 2,  5,  9,   65547,        32,     2'b01, 1, 32'h20,       1);
    add(0, 0, 0,  0,            0, 5,  5,  9,   0,            0,      2'b00, 1, 32'h0,        0);
    add(0, 0, 0,  0,            0, 2,  1,  2,   0,            0,      2'b00, 1, 32'h0,        0);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ie, vecs[i].ia, vecs[i].ra0, vecs[i].ra1);
      #1;
      chk("rd_data0",  i, rd_data[31:0],  vecs[i].d0);
      chk("rd_data1",  i, rd_data[63:32], vecs[i].d1);
      chk("rd_busy",   i, 32'(rd_busy),   32'(vecs[i].busy));
      chk("iss_ready", i, 32'(iss_ready), 32'(vecs[i].irdy));
      chk("busy_vec",  i, busy_vec,       vecs[i].bvec);
      chk("err_underflow", i, 32'(err_underflow), 32'(vecs[i].err));
      $display("[TB] row %0d: we=%0d wa=%0d ie=%0d ia=%0d ra={%0d,%0d} d0=%h d1=%h busy=%b rdy=%0d bvec=%h err=%0d",
               i, wr_en, wr_addr, iss_en, iss_addr, vecs[i].ra1, vecs[i].ra0,
               rd_data[31:0], rd_data[63:32], rd_busy, iss_ready, busy_vec, err_underflow);
    end

    // Hand sequence: fill x10 to the limit, then drain it with three writebacks.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 10, 10, 0);
      #1;
      chk("fill_ready", 100 + k, 32'(iss_ready), (k < 3) ? 32'd1 : 32'd0);
      chk("fill_busy_vec", 100 + k, busy_vec, (k == 0) ? 32'h0 : 32'h400);
      $display("[TB] fill %0d: iss_ready=%0d busy_vec=%h", k, iss_ready, busy_vec);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 1, 10, 32'(100 + k), 0, 10, 10, 0);
      #1;
      chk("drain_busy", 200 + k, 32'(rd_busy[0]), (k < 2) ? 32'd1 : 32'd0);
      chk("drain_data", 200 + k, rd_data[31:0], 32'(100 + k));
      $display("[TB] drain %0d: rd_busy=%b rd_data0=%h", k, rd_busy, rd_data[31:0]);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 10, 0);
    #1;
    chk("drain_busy_vec", 300, busy_vec, 32'h0);
    chk("drain_err", 300, 32'(err_underflow), 32'd0);
    chk("drain_stored", 300, rd_data[31:0], 32'd102);
    $display("[TB] drained: busy_vec=%h err=%0d x10=%h", busy_vec, err_underflow, rd_data[31:0]);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Parametrised register file for the pipelined RISC-V core, replacing the fixed 32x32, 2-read/1-write register file. It adds a configurable number of read ports, same-cycle write-to-read bypass and a per-register pending-write scoreboard. Decode uses the scoreboard for hazard detection, and writeback drives the write port. Register 0 reads as zero and is never busy.

## Interface
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of two, at least 2.
- NREAD, 2, number of read ports; range 1 to 4.
- MAX_PEND, 3, maximum outstanding writes per register; at least 1.
- Derived (localparam): AW = $clog2(NREG); CW = $clog2(MAX_PEND+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NREAD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  out  NREAD  port i source register has a pending write.
- wr_en  in  1  writeback valid.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  issue request: mark iss_addr as pending.
- iss_addr  in  AW  issued destination register.
- iss_ready  out  1  issue to iss_addr can be accepted this cycle.
- busy_vec  out  NREG  bit r is 1 when pend[r] != 0; bit 0 is always 0.
- err_underflow  out  1  sticky: a writeback hit a register with no pending write.

## Operation
- Storage: regs[1..NREG-1] of XLEN bits. There is no physical register 0.
- Each register has a pending counter pend[r] of CW bits. pend[0] is constant 0.
- Reads are combinational:
  - rd_data[i] = 0 if rd_addr[i] == 0.
  - Otherwise rd_data[i] = wr_data if wr_en and wr_addr == rd_addr[i] (bypass).
  - Otherwise rd_data[i] = regs[rd_addr[i]].
- Write: on the clock edge, if wr_en and wr_addr != 0, regs[wr_addr] <= wr_data. Writes to register 0 are discarded.
- Issue acceptance:
  - iss_ready = (iss_addr == 0) or (pend[iss_addr] != MAX_PEND) or (wr_en and wr_addr == iss_addr and pend[iss_addr] != 0).
  - The issue is accepted when iss_en and iss_ready. An issue with iss_ready = 0 has no effect.
- Counter update for register r != 0:
  - inc = an accepted issue with iss_addr == r.
  - dec = wr_en with wr_addr == r and pend[r] != 0.
  - inc and not dec: pend[r] + 1. dec and not inc: pend[r] - 1. Both or neither: unchanged.
  - The counter never wraps.
- Underflow: wr_en with wr_addr != 0 and pend[wr_addr] == 0 still writes data, leaves the counter at 0, and sets err_underflow. The flag clears only on rst.
- rd_busy[i] = (rd_addr[i] != 0) and (pend[rd_addr[i]] > dec_i), where dec_i is 1 if this cycle's writeback targets rd_addr[i]. A register whose last pending write retires this cycle reads as not busy, and the bypassed data is returned.
- rd_busy ignores any same-cycle issue.

## Timing
- Reset (synchronous, rst high at the edge):
  - All regs are cleared to 0, all pend counters to 0, err_underflow to 0.
  - After the reset edge: rd_data = 0 on every port, rd_busy = 0, busy_vec = 0.
  - iss_ready = 1 after the reset edge.
  - rst has priority over a same-cycle write or issue; those are dropped.
  - Reset mid-operation discards all in-flight pending state.
- Read latency is 0 cycles (combinational). Write-to-read latency is 0 cycles through the bypass, then 1 cycle from storage.
- The busy_vec update is visible 1 cycle after an issue or writeback edge.
- There is no internal pipelining. Every output depends only on current inputs and state updated at the previous edge.

## Test plan
- **Basic write/read:** write x1 = 50, then x2 = 20 on consecutive edges; set rd_addr = {2, 1}. Required: rd_data port0 = 50, port1 = 20, rd_busy = 00.
- **Register 0:** write x0 = 32'd5; read x0 on both ports. Required: rd_data = 0 and busy_vec[0] = 0. Also issue to x0 with iss_ready = 1: busy_vec stays 0.
- **Bypass:** in the same cycle, wr_en with x3 = 2147483653 and rd_addr port0 = 3. Required: port0 = 32'h80000005 in that cycle. After the edge, it is still 32'h80000005 with wr_en low.
- **Scoreboard saturation (MAX_PEND = 3):**
  - Issue x5 on three edges. Required: busy_vec[5] = 1 and iss_ready = 0 for x5.
  - A fourth iss_en is ignored.
  - Three writebacks to x5 (values 8, 10, 65547). Required: busy_vec[5] clears after the third edge and regs[5] = 65547.
  - On the third writeback cycle with rd_addr = 5: rd_busy = 0 and rd_data = 65547.
- **Simultaneous issue and writeback:** with pend[7] = 1, issue x7 and write back x7 = 28 in the same cycle. Required: pend[7] stays 1, regs[7] = 28, and err_underflow = 0.
- **Underflow and reset:**
  - Write x9 = 32 with pend[9] = 0. Required: regs[9] = 32 and err_underflow = 1.
  - Then assert rst for one edge while x5 is pending. Required: err_underflow = 0, busy_vec = 0, and all reads return 0.
